// File: rtl/ldpc_pkg.sv
// Shared types and default dimensions for the LDPC receive path.
// Bank states, codeword geometry and index-width helper.
package ldpc_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        DEC     = 2'd3
    } bank_state_t;

    localparam int DATA_W = 6;
    localparam int Z      = 27;
    localparam int NBLK   = 24;
    localparam int CW_LEN = Z * NBLK;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BLK_W = idx_w(NBLK);

endpackage

// File: rtl/llr_bank.sv
// One codeword of LLR storage: single-LLR write port, registered
// block-column read port returning z LLRs at once.
module llr_bank
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int z      = Z,
    parameter int nblk   = NBLK
) (
    input  logic                      clk,
    input  logic                      wr_en_i,
    input  logic [idx_w(nblk)-1:0]    wr_blk_i,
    input  logic [idx_w(z)-1:0]       wr_lane_i,
    input  logic [data_w-1:0]         wr_data_i,
    input  logic                      rd_en_i,
    input  logic [idx_w(nblk)-1:0]    rd_blk_i,
    output logic [z*data_w-1:0]       rd_word_o
);

    logic [data_w-1:0]   mem_q [nblk][z];
    logic [z*data_w-1:0] rd_word_q;

    // Storage is deliberately not reset; the owner gates readability by bank state.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_blk_i][wr_lane_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            for (int k = 0; k < z; k++) begin
                rd_word_q[k*data_w +: data_w] <= mem_q[rd_blk_i][k];
            end
        end
    end

    assign rd_word_o = rd_word_q;

endmodule

// File: rtl/llr_buffer.sv
// Ping-pong channel-LLR buffer: serial fill of one bank while the decoder
// reads the other bank as z-wide block columns.
module llr_buffer
    import ldpc_pkg::*;
#(
    parameter int data_w = DATA_W,
    parameter int z      = Z,
    parameter int nblk   = NBLK
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [data_w-1:0]         llr_in,
    output logic                      cw_rdy,
    input  logic                      cw_ack,
    input  logic                      cw_done,
    input  logic                      rd_en,
    input  logic [idx_w(nblk)-1:0]    rd_blk,
    output logic                      rd_valid,
    output logic                      rd_err,
    output logic [z*data_w-1:0]       rd_data
);

    localparam int BLK_W  = idx_w(nblk);
    localparam int LANE_W = idx_w(z);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(nblk - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(z - 1);
    localparam logic [BLK_W:0]    BLK_LIMIT = (BLK_W + 1)'(nblk);

    bank_state_t         state_q [2];
    bank_state_t         state_d [2];
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [BLK_W-1:0]    wr_blk_q, wr_blk_d;
    logic [LANE_W-1:0]   wr_lane_q, wr_lane_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_err_q, rd_err_d;
    logic                rd_zero_q, rd_zero_d;
    logic                rd_sel_q, rd_sel_d;

    logic                accept;
    logic                last_sample;
    logic                rd_dec;
    logic                rd_in_range;
    logic [BLK_W-1:0]    eff_blk;
    logic [LANE_W-1:0]   eff_lane;
    logic [z*data_w-1:0] bank_word [2];

    assign in_ready    = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
    assign cw_rdy      = (state_q[rd_bank_q] == FULL);
    assign rd_dec      = (state_q[rd_bank_q] == DEC);
    assign accept      = in_valid && in_ready;
    assign eff_blk     = in_sof ? '0 : wr_blk_q;
    assign eff_lane    = in_sof ? '0 : wr_lane_q;
    assign last_sample = (eff_blk == BLK_LAST) && (eff_lane == LANE_LAST);
    assign rd_in_range = ({1'b0, rd_blk} < BLK_LIMIT);

    // The write counter is kept as (block, lane) so banks never need a divider.
    genvar b;
    for (b = 0; b < 2; b++) begin : g_bank
        llr_bank #(
            .data_w (data_w),
            .z      (z),
            .nblk   (nblk)
        ) u_bank (
            .clk       (clk),
            .wr_en_i   (accept && (wr_bank_q == 1'(b))),
            .wr_blk_i  (eff_blk),
            .wr_lane_i (eff_lane),
            .wr_data_i (llr_in),
            .rd_en_i   (rd_en && rd_dec && rd_in_range && (rd_bank_q == 1'(b))),
            .rd_blk_i  (rd_blk),
            .rd_word_o (bank_word[b])
        );
    end

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_blk_d   = wr_blk_q;
        wr_lane_d  = wr_lane_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        rd_zero_d  = rd_zero_q;
        rd_sel_d   = rd_sel_q;

        if (accept) begin
            if (last_sample) begin
                state_d[wr_bank_q] = FULL;
                wr_blk_d           = '0;
                wr_lane_d          = '0;
                wr_bank_d          = ~wr_bank_q;
            end else begin
                state_d[wr_bank_q] = FILLING;
                if (eff_lane == LANE_LAST) begin
                    wr_lane_d = '0;
                    wr_blk_d  = eff_blk + 1'b1;
                end else begin
                    wr_lane_d = eff_lane + 1'b1;
                    wr_blk_d  = eff_blk;
                end
            end
        end

        // Filling only touches EMPTY/FILLING banks and the decoder side only
        // FULL/DEC banks, so these updates never target the same bank.
        if (cw_ack && (state_q[rd_bank_q] == FULL)) begin
            state_d[rd_bank_q] = DEC;
        end
        if (cw_done && rd_dec) begin
            state_d[rd_bank_q] = EMPTY;
            rd_bank_d          = ~rd_bank_q;
        end

        if (rd_en && rd_dec) begin
            rd_valid_d = 1'b1;
            rd_err_d   = ~rd_in_range;
            rd_zero_d  = ~rd_in_range;
            if (rd_in_range) begin
                rd_sel_d = rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_blk_q   <= '0;
            wr_lane_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_zero_q  <= 1'b1;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_blk_q   <= wr_blk_d;
            wr_lane_q  <= wr_lane_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_zero_q  <= rd_zero_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    // Bank words hold their last loaded value, so an unserviced read leaves rd_data unchanged.
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = rd_zero_q ? '0 : bank_word[rd_sel_q];

endmodule

// File: tb/tb_llr_buffer.sv
// Directed bench for llr_buffer with z=4, nblk=3 (12-LLR codewords).
module tb_llr_buffer;

    localparam int DW = 6;
    localparam int ZZ = 4;
    localparam int NB = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_sof;
    logic [DW-1:0]  llr_in;
    logic           cw_rdy, cw_ack, cw_done;
    logic           rd_en;
    logic [1:0]     rd_blk;
    logic           rd_valid, rd_err;
    logic [ZZ*DW-1:0] rd_data;

    int checks   = 0;
    int failures = 0;

    llr_buffer #(.data_w(DW), .z(ZZ), .nblk(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sof   (in_sof),
        .llr_in   (llr_in),
        .cw_rdy   (cw_rdy),
        .cw_ack   (cw_ack),
        .cw_done  (cw_done),
        .rd_en    (rd_en),
        .rd_blk   (rd_blk),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sof, input int v);
        in_valid = 1'b1;
        in_sof   = sof;
        llr_in   = DW'(v);
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic pulse_ack();
        cw_ack = 1'b1;
        tick();
        cw_ack = 1'b0;
    endtask

    task automatic pulse_done();
        cw_done = 1'b1;
        tick();
        cw_done = 1'b0;
    endtask

    task automatic read_blk(input int blk);
        rd_en  = 1'b1;
        rd_blk = 2'(blk);
        tick();
        rd_en  = 1'b0;
    endtask

    // Lane 0 is the lowest-indexed LLR of the block.
    function automatic logic [ZZ*DW-1:0] word4(input int l0, input int l1, input int l2, input int l3);
        return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_sof = 0; llr_in = '0;
        cw_ack = 0; cw_done = 0; rd_en = 0; rd_blk = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (cw_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_cw_rdy got=%0b exp=0", cw_rdy); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_err got=%0b exp=0", rd_err); end
        checks++; if (rd_data !== '0) begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=0", rd_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 11; i++) send(i == 0, i);
        checks++; if (cw_rdy !== 1'b0) begin failures++; $display("[TB] FAIL fill_cw_rdy_early got=%0b exp=0", cw_rdy); end
        send(1'b0, 11);
        checks++; if (cw_rdy !== 1'b1) begin failures++; $display("[TB] FAIL fill_cw_rdy got=%0b exp=1", cw_rdy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_read();
        logic [ZZ*DW-1:0] exp;
        pulse_ack();
        checks++; if (cw_rdy !== 1'b0) begin failures++; $display("[TB] FAIL read_ack_cw_rdy got=%0b exp=0", cw_rdy); end
        rd_en = 1'b1;
        for (int b = 0; b < 3; b++) begin
            rd_blk = 2'(b);
            tick();
            exp = word4(4*b, 4*b+1, 4*b+2, 4*b+3);
            checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== exp) begin
                failures++; $display("[TB] FAIL read_blk%0d got v=%0b e=%0b d=%h exp v=1 e=0 d=%h", b, rd_valid, rd_err, rd_data, exp);
            end
        end
        rd_blk = 2'd3;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== '0) begin
            failures++; $display("[TB] FAIL read_oor got v=%0b e=%0b d=%h exp v=1 e=1 d=0", rd_valid, rd_err, rd_data);
        end
        rd_blk  = 2'd1;
        cw_done = 1'b1;
        tick();
        cw_done = 1'b0;
        rd_en   = 1'b0;
        exp = word4(4, 5, 6, 7);
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin
            failures++; $display("[TB] FAIL read_with_done got v=%0b d=%h exp v=1 d=%h", rd_valid, rd_data, exp);
        end
        read_blk(2);
        checks++; if (rd_valid !== 1'b0 || rd_data !== exp) begin
            failures++; $display("[TB] FAIL read_not_dec got v=%0b d=%h exp v=0 d=%h", rd_valid, rd_data, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [ZZ*DW-1:0] exp;
        for (int i = 0; i < 12; i++) send(i == 0, 12 + i);
        checks++; if (cw_rdy !== 1'b1 || in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL b2b_first got rdy=%0b in_ready=%0b exp 1 1", cw_rdy, in_ready);
        end
        for (int i = 0; i < 12; i++) send(i == 0, 24 + i);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_stall got=%0b exp=0", in_ready); end
        in_valid = 1'b1; in_sof = 1'b1; llr_in = DW'(5);
        tick(); tick(); tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL b2b_hold got=%0b exp=0", in_ready); end
        pulse_ack();
        checks++; if (in_ready !== 1'b0 || cw_rdy !== 1'b0) begin
            failures++; $display("[TB] FAIL b2b_ack got in_ready=%0b rdy=%0b exp 0 0", in_ready, cw_rdy);
        end
        read_blk(0);
        exp = word4(12, 13, 14, 15);
        checks++; if (rd_data !== exp) begin failures++; $display("[TB] FAIL b2b_intact got=%h exp=%h", rd_data, exp); end
        pulse_done();
        checks++; if (in_ready !== 1'b1 || cw_rdy !== 1'b1) begin
            failures++; $display("[TB] FAIL b2b_release got in_ready=%0b rdy=%0b exp 1 1", in_ready, cw_rdy);
        end
        tick();
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic test_overlap();
        logic [ZZ*DW-1:0] exp;
        pulse_ack();
        read_blk(2);
        exp = word4(32, 33, 34, 35);
        checks++; if (rd_data !== exp || rd_valid !== 1'b1) begin
            failures++; $display("[TB] FAIL ovl_bank0_read got v=%0b d=%h exp v=1 d=%h", rd_valid, rd_data, exp);
        end
        for (int i = 1; i < 11; i++) send(1'b0, 50 + i);
        checks++; if (cw_rdy !== 1'b0) begin failures++; $display("[TB] FAIL ovl_early got=%0b exp=0", cw_rdy); end
        in_valid = 1'b1; llr_in = DW'(61); cw_done = 1'b1;
        tick();
        in_valid = 1'b0; cw_done = 1'b0;
        checks++; if (cw_rdy !== 1'b1 || in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL ovl_same_cycle got rdy=%0b in_ready=%0b exp 1 1", cw_rdy, in_ready);
        end
        pulse_ack();
        read_blk(0);
        exp = word4(5, 51, 52, 53);
        checks++; if (rd_data !== exp) begin failures++; $display("[TB] FAIL ovl_bank1_blk0 got=%h exp=%h", rd_data, exp); end
        read_blk(2);
        exp = word4(58, 59, 60, 61);
        checks++; if (rd_data !== exp) begin failures++; $display("[TB] FAIL ovl_bank1_blk2 got=%h exp=%h", rd_data, exp); end
        pulse_done();
        checks++; if (cw_rdy !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL ovl_idle got rdy=%0b in_ready=%0b exp 0 1", cw_rdy, in_ready);
        end
    endtask

    task automatic test_resync();
        logic [ZZ*DW-1:0] exp;
        for (int i = 0; i < 5; i++) send(i == 0, i + 1);
        send(1'b1, 33);
        for (int i = 1; i < 11; i++) send(1'b0, 40 + i);
        checks++; if (cw_rdy !== 1'b0) begin failures++; $display("[TB] FAIL resync_early got=%0b exp=0", cw_rdy); end
        send(1'b0, 51);
        checks++; if (cw_rdy !== 1'b1) begin failures++; $display("[TB] FAIL resync_done got=%0b exp=1", cw_rdy); end
        pulse_ack();
        read_blk(0);
        exp = word4(33, 41, 42, 43);
        checks++; if (rd_data !== exp) begin failures++; $display("[TB] FAIL resync_blk0 got=%h exp=%h", rd_data, exp); end
        read_blk(2);
        exp = word4(48, 49, 50, 51);
        checks++; if (rd_data !== exp) begin failures++; $display("[TB] FAIL resync_blk2 got=%h exp=%h", rd_data, exp); end
    endtask

    task automatic test_reset_mid_decode();
        logic [ZZ*DW-1:0] exp;
        for (int i = 0; i < 3; i++) send(i == 0, 9);
        read_blk(1);
        exp = word4(44, 45, 46, 47);
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp) begin
            failures++; $display("[TB] FAIL rmd_pre got v=%0b d=%h exp v=1 d=%h", rd_valid, rd_data, exp);
        end
        rst = 1'b1;
        #2;
        checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || rd_data !== '0) begin
            failures++; $display("[TB] FAIL rmd_outputs got v=%0b e=%0b d=%h exp 0 0 0", rd_valid, rd_err, rd_data);
        end
        checks++; if (in_ready !== 1'b1 || cw_rdy !== 1'b0) begin
            failures++; $display("[TB] FAIL rmd_flags got in_ready=%0b rdy=%0b exp 1 0", in_ready, cw_rdy);
        end
        #1;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 11; i++) send(1'b0, 20 + i);
        checks++; if (cw_rdy !== 1'b0) begin failures++; $display("[TB] FAIL rmd_early got=%0b exp=0", cw_rdy); end
        send(1'b0, 31);
        checks++; if (cw_rdy !== 1'b1) begin failures++; $display("[TB] FAIL rmd_refill got=%0b exp=1", cw_rdy); end
        pulse_ack();
        read_blk(0);
        exp = word4(20, 21, 22, 23);
        checks++; if (rd_data !== exp) begin failures++; $display("[TB] FAIL rmd_bank0 got=%h exp=%h", rd_data, exp); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read();
        test_back_to_back();
        test_overlap();
        test_resync();
        test_reset_mid_decode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/llr_buffer.md
# llr_buffer

Ping-pong channel-LLR buffer between the quantiser and the LDPC decoder core. Accepts one quantised LLR per cycle, serially, in codeword order, and stores it into one of two codeword banks. Hands a completed bank to the decoder, which reads it as Z-wide block columns. The other bank keeps filling, so input streaming overlaps decoding of the previous codeword.

## Interface
Parameters:
- data_w, 6: LLR width in bits; matches the quantiser output.
- z, 27: lifting factor; LLRs returned per read.
- nblk, 24: block columns per codeword; codeword length cw_len = z*nblk (default 648).

Ports:
- clk  in  1: sole clock; all state updates on the rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: llr_in is valid.
- in_ready  out  1: buffer can accept a sample.
- in_sof  in  1: start of codeword; qualified by in_valid & in_ready.
- llr_in  in  data_w: signed LLR from the quantiser.
- cw_rdy  out  1: a full bank is waiting for the decoder.
- cw_ack  in  1: one-cycle pulse; decoder claims the waiting bank.
- cw_done  in  1: one-cycle pulse; decoder releases the bank it holds.
- rd_en  in  1: read request.
- rd_blk  in  $clog2(nblk): block-column index.
- rd_valid  out  1: rd_data holds a valid read result.
- rd_err  out  1: rd_blk was out of range on the accepted request.
- rd_data  out  z*data_w: lane k = bits [k*data_w +: data_w] = LLR index rd_blk*z+k.

## Operation
- Each bank has a state: EMPTY, FILLING, FULL or DEC.
- Pointers: wr_bank (bank being filled), rd_bank (bank next or currently used by the decoder), wr_cnt (0..cw_len-1).
- in_ready = state[wr_bank] is EMPTY or FILLING. It is combinational from registered state.
- Accepted sample (in_valid & in_ready):
  - Written to index wr_cnt, or to index 0 if in_sof=1.
  - state[wr_bank] becomes FILLING.
  - wr_cnt increments; with in_sof=1 it becomes 1.
- in_sof while wr_cnt≠0: the partial codeword is discarded and the bank restarts at index 0. No error flag is raised.
- Sample accepted at index cw_len-1:
  - state[wr_bank] becomes FULL.
  - wr_cnt resets to 0.
  - wr_bank toggles.
- cw_rdy = (state[rd_bank]==FULL).
- cw_ack while cw_rdy: state[rd_bank] becomes DEC. cw_ack at any other time is ignored.
- cw_done while state[rd_bank]==DEC: state[rd_bank] becomes EMPTY and rd_bank toggles. cw_done at any other time is ignored.
- Read while state[rd_bank]==DEC: next cycle, rd_valid=1 and rd_data holds block rd_blk of rd_bank.
  - If rd_blk≥nblk: rd_data=0, rd_valid=1, rd_err=1.
  - A read issued in the same cycle as cw_done is still serviced from the releasing bank.
- Read while not DEC: rd_valid=0 next cycle and rd_data holds its previous value.
- Simultaneous events:
  - Fill completion on one bank and cw_ack/cw_done on the other are independent; both take effect in the same cycle.
  - When both banks are FULL or DEC, in_ready=0. Input stalls; no sample is lost or overwritten.
  - cw_done on a bank and in_ready rising for that bank: the bank is writable on the next cycle, not the same cycle.
- Reset (asynchronous, any time, including mid-fill or mid-decode):
  - Both banks EMPTY; wr_bank=0, rd_bank=0, wr_cnt=0.
  - rd_valid=0, rd_err=0, rd_data=0.
  - Therefore in_ready=1 and cw_rdy=0.
  - Storage contents are not cleared; EMPTY state makes them unreadable.

## Timing
- Input throughput: 1 LLR per cycle while in_ready=1.
- Last sample accepted at edge t: cw_rdy=1 from t+1.
- cw_ack at t: cw_rdy=0 from t+1, and reads are serviced from t+1.
- Read latency: exactly 1 cycle, with registered rd_data/rd_valid/rd_err. Sustained rate is 1 read per cycle.
- cw_done at t: the released bank is EMPTY from t+1. in_ready may rise at t+1 if that bank is wr_bank.
- No combinational path from any input to any output except in_valid-independent in_ready, which derives from state only.

## Structure
- Package ldpc_pkg holds:
  - the bank-state enum (EMPTY=0, FILLING=1, FULL=2, DEC=3);
  - the default data_w, z and nblk;
  - the derived cw_len and block-index width.
- One sub-module, llr_bank, instantiated twice:
  - write port: one data_w word at an index;
  - read port: one registered z*data_w word at a block index.
- llr_buffer itself holds the bank-state registers, the pointers, the handshake logic and the output mux.

## Test plan
Bench parameters: z=4, nblk=3 (cw_len=12), data_w=6.
- Fill: stream values 0..11 with in_sof on the first sample → cw_rdy=1 one cycle after the 12th accept; in_ready stays 1 (bank1 is EMPTY).
- Read: cw_ack, then rd_blk=0,1,2 on consecutive cycles → rd_data lanes {3,2,1,0}, {7,6,5,4}, {11,10,9,8} (lane 3 first), each one cycle after its request. rd_blk=3 → rd_data=0, rd_err=1.
- Back-pressure: fill two codewords without cw_ack → in_ready=0 after the 24th accept; a 25th in_valid is held off. cw_ack then cw_done → in_ready=1 the cycle after cw_done.
- Overlap: fill bank1 while decoding bank0, with the 12th bank1 accept in the same cycle as cw_done → bank0 EMPTY, bank1 FULL, cw_rdy=1 next cycle.
- Resync: accept 5 samples, then in_sof with value 33 → a later read of block 0 lane 0 returns 33; the codeword completes after 12 accepts counted from the in_sof.
- Reset mid-decode: assert rst during DEC → outputs match reset values immediately; a new 12-sample fill produces cw_rdy on bank0.
